// File: rtl/fetch_unit_pkg.sv
// Shared types and constants for the instruction fetch unit.
package fetch_unit_pkg;

  localparam int unsigned XLEN = 32;
  localparam logic [XLEN-1:0] PC_INC = 32'd4;

  typedef enum logic {
    RUN   = 1'b0,
    DRAIN = 1'b1
  } fetch_state_e;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] inst;
  } buf_entry_t;

endpackage

// File: rtl/fetch_unit_if.sv
// Fetch unit bus bundle: redirect input, imem request/response, decode output.
interface fetch_unit_if;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst_data;
  logic [31:0] inst_pc;

  // Fetch unit side
  modport master (
    input  redirect_valid, redirect_pc,
    output imem_req_valid, imem_req_addr,
    input  imem_req_ready,
    input  imem_rsp_valid, imem_rsp_data,
    output inst_valid, inst_data, inst_pc,
    input  inst_ready
  );

  // Environment side (memory, next-PC logic, decode)
  modport slave (
    output redirect_valid, redirect_pc,
    input  imem_req_valid, imem_req_addr,
    output imem_req_ready,
    output imem_rsp_valid, imem_rsp_data,
    input  inst_valid, inst_data, inst_pc,
    output inst_ready
  );
endinterface

// File: rtl/fetch_buf.sv
// Synchronous FIFO of {pc, inst} entries with a single-cycle flush.
module fetch_buf
  import fetch_unit_pkg::*;
#(
  parameter int unsigned DEPTH = 2,
  localparam int unsigned CW = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_flush,
  input  logic          i_push,
  input  buf_entry_t    i_push_data,
  input  logic          i_pop,
  output logic          o_valid,
  output buf_entry_t    o_head,
  output logic [CW-1:0] o_count
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  buf_entry_t    r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          w_push;
  logic          w_pop;

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  // Pop only when non-empty; push at full allowed only together with a pop
  assign w_pop  = i_pop && (r_count != '0);
  assign w_push = i_push && ((r_count < CW'(DEPTH)) || w_pop);

  // Storage, pointers and occupancy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) r_mem[i] <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= i_push_data;
        r_wr_ptr        <= ptr_inc(r_wr_ptr);
      end
      if (w_pop) r_rd_ptr <= ptr_inc(r_rd_ptr);
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
    end
  end

  assign o_valid = (r_count != '0);
  assign o_head  = r_mem[r_rd_ptr];
  assign o_count = r_count;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch unit: credit-limited in-order imem requests, response
// buffering, redirect with stale-response draining.
// Optional macro FETCH_PERF_CNT_EN adds perf_fetch_cnt / perf_flush_cnt.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int unsigned BUF_DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  fetch_unit_if.master bus
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]  perf_fetch_cnt,
  output logic [31:0]  perf_flush_cnt
`endif
);

  localparam int unsigned CW = $clog2(BUF_DEPTH + 1);

  fetch_state_e  r_state;
  logic [31:0]   r_pc;
  logic [31:0]   r_rsp_pc;
  logic [CW-1:0] r_out;
  logic          r_req_valid;

  fetch_state_e  w_state_nxt;
  logic [CW-1:0] w_out_nxt;
  logic [CW-1:0] w_occ;
  logic [CW-1:0] w_occ_nxt;
  logic [CW:0]   w_credit;
  logic          w_req_valid_nxt;
  logic          w_req_fire;
  logic          w_rsp_ok;
  logic          w_push;
  logic          w_pop;
  logic          w_buf_valid;
  logic          w_inst_valid;
  logic [31:0]   w_target;
  buf_entry_t    w_head;
  buf_entry_t    w_push_data;

  assign w_req_fire   = r_req_valid && bus.imem_req_ready;
  // A response with nothing outstanding is spurious and ignored
  assign w_rsp_ok     = bus.imem_rsp_valid && (r_out != '0);
  assign w_push       = w_rsp_ok && (r_state == RUN) && !bus.redirect_valid;
  assign w_inst_valid = w_buf_valid && !bus.redirect_valid;
  assign w_pop        = w_inst_valid && bus.inst_ready;
  assign w_target     = {bus.redirect_pc[31:2], 2'b00};
  assign w_push_data  = '{pc: r_rsp_pc, inst: bus.imem_rsp_data};

  // Next-cycle accounting; in DRAIN no requests issue, so the outstanding
  // count doubles as the number of responses still to be dropped
  always_comb begin
    w_out_nxt   = r_out + CW'(w_req_fire) - CW'(w_rsp_ok);
    w_occ_nxt   = bus.redirect_valid ? '0 : (w_occ + CW'(w_push) - CW'(w_pop));
    w_state_nxt = RUN;
    if ((w_out_nxt != '0) && (bus.redirect_valid || (r_state == DRAIN))) begin
      w_state_nxt = DRAIN;
    end
    w_credit        = {1'b0, w_out_nxt} + {1'b0, w_occ_nxt};
    w_req_valid_nxt = (w_state_nxt == RUN) && (w_credit < (CW + 1)'(BUF_DEPTH));
  end

  // FSM, fetch PC, response PC tracker, outstanding count, request valid
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= RUN;
      r_pc        <= RESET_PC;
      r_rsp_pc    <= RESET_PC;
      r_out       <= '0;
      r_req_valid <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_out       <= w_out_nxt;
      r_req_valid <= w_req_valid_nxt;
      if (bus.redirect_valid)  r_pc <= w_target;
      else if (w_req_fire)     r_pc <= r_pc + PC_INC;
      if (bus.redirect_valid)  r_rsp_pc <= w_target;
      else if (w_push)         r_rsp_pc <= r_rsp_pc + PC_INC;
    end
  end

  fetch_buf #(.DEPTH(BUF_DEPTH)) u_buf (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_flush     (bus.redirect_valid),
    .i_push      (w_push),
    .i_push_data (w_push_data),
    .i_pop       (w_pop),
    .o_valid     (w_buf_valid),
    .o_head      (w_head),
    .o_count     (w_occ)
  );

  assign bus.imem_req_valid = r_req_valid;
  assign bus.imem_req_addr  = r_pc;
  assign bus.inst_valid     = w_inst_valid;
  assign bus.inst_data      = w_head.inst;
  assign bus.inst_pc        = w_head.pc;

`ifdef FETCH_PERF_CNT_EN
  // Wrapping counters of decode handshakes and redirects
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_fetch_cnt <= '0;
      perf_flush_cnt <= '0;
    end else begin
      if (w_pop)              perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
      if (bus.redirect_valid) perf_flush_cnt <= perf_flush_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, is the PC loaded at reset.
REQ-002 Parameter BUF_DEPTH, default 2, is the number of instruction-buffer entries and the maximum in-flight requests.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset; asynchronous, active-low.
REQ-005 redirect_valid  input  1  taken branch/jump this cycle.
REQ-006 redirect_pc  input  32  target PC from the next-PC calculator.
REQ-007 imem_req_valid  output  1  fetch request valid.
REQ-008 imem_req_ready  input  1  memory accepts request.
REQ-009 imem_req_addr  output  32  fetch address.
REQ-010 imem_rsp_valid  input  1  instruction word returned; responses arrive in request order.
REQ-011 imem_rsp_data  input  32  returned instruction word.
REQ-012 inst_valid  output  1  instruction available to decode.
REQ-013 inst_ready  input  1  decode accepts instruction.
REQ-014 inst_data  output  32  instruction word.
REQ-015 inst_pc  output  32  PC of inst_data.

Function
REQ-016 Request handshake occurs when imem_req_valid && imem_req_ready; fetch PC then advances by 4, modulo 2^32 (32'hFFFF_FFFC wraps to 0).
REQ-017 imem_req_valid is asserted in RUN only when outstanding + buffer occupancy < BUF_DEPTH; imem_req_addr equals fetch PC and holds stable while valid and not ready.
REQ-018 Each accepted response is written into the FIFO buffer paired with its request PC; latency from response to inst_valid is one cycle.
REQ-019 Buffer output handshake occurs when inst_valid && inst_ready; the head entry is then popped; simultaneous push and pop are supported at full occupancy.
REQ-020 FSM states: RUN (normal fetch) and DRAIN (discarding stale responses).
REQ-021 On redirect_valid: fetch PC <= {redirect_pc[31:2],2'b00}, buffer flushed, inst_valid forced 0 that cycle (no decode handshake), any response that cycle discarded.
REQ-022 On redirect with outstanding > 0 after that cycle's accounting (including a request accepted that same cycle), go to DRAIN with drop count = outstanding; otherwise stay in RUN.
REQ-023 In DRAIN: no requests issued, each response decrements the drop count and is discarded; at drop count 0 return to RUN.
REQ-024 Redirect during DRAIN reloads fetch PC and keeps the current drop count (plus any request accepted that cycle); remains in DRAIN.
REQ-025 Responses never exceed outstanding; a response with outstanding = 0 is ignored.

Reset
REQ-026 While rst_n low: fetch PC = RESET_PC, state = RUN, outstanding = 0, buffer empty, imem_req_valid = 0, inst_valid = 0, inst_data = 0, inst_pc = 0.
REQ-027 Reset asserted mid-operation discards all in-flight and buffered instructions; first request after release uses RESET_PC.

Configuration
REQ-028 With FETCH_PERF_CNT_EN defined: outputs perf_fetch_cnt (32) counting decode handshakes and perf_flush_cnt (32) counting redirects, both wrapping, reset to 0; without it these ports and counters do not exist.

Structure
REQ-029 Shared package holds the state enum (RUN, DRAIN), the PC increment constant 4, and the buffer entry struct {pc, inst}.
REQ-030 Buffer is a sub-module fetch_buf (synchronous FIFO, BUF_DEPTH entries, flush input).

Verification
REQ-031 Reset release, memory always ready, 1-cycle response -> requests at 0x0, 0x4, 0x8; inst_pc sequence 0x0, 0x4, 0x8 with matching data.
REQ-032 inst_ready held 0 -> exactly 2 requests issued, imem_req_valid drops, buffer holds 0x0 and 0x4.
REQ-033 Redirect to 0x103 with 2 outstanding -> DRAIN, next 2 responses discarded, next request addr 0x100.
REQ-034 Redirect coincident with inst handshake and a response -> no instruction delivered, response dropped, next delivered inst_pc = target.
REQ-035 Redirect to 0xFFFF_FFFC -> requests 0xFFFF_FFFC then 0x0000_0000.
REQ-036 rst_n asserted while DRAIN with 1 outstanding -> all outputs at reset values, fetch restarts at RESET_PC, late response ignored.
